// File: rtl/sample_fifo_if.sv
// Handshake bundle between the byte producer (host) and the sample FIFO.
// The master drives writes, pops and flush; the FIFO drives status and data.
interface sample_fifo_if #(
  parameter int DEPTH = 1024
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          almost_full;
  logic          read;
  logic [7:0]    sample;
  logic          empty;
  logic [LW-1:0] level;
  logic          overflow;
  logic          underflow;

  modport master (
    output flush, wr_en, wr_data, read,
    input  full, almost_full, sample, empty, level, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, read,
    output full, almost_full, sample, empty, level, overflow, underflow
  );
endinterface

// File: rtl/sample_fifo.sv
// Byte FIFO with first-word-fall-through head register.
// Bytes land in a RAM first; the oldest byte is moved into the head register
// as soon as the head is free (or being consumed), so sample is valid whenever
// empty is low and back-to-back pops are served without a bubble.
// level counts RAM bytes plus the head byte; full/almost_full/empty are all
// registered from next-state values, so there is no combinational path from
// wr_en/read to the status outputs.
module sample_fifo #(
  parameter int DEPTH     = 1024,
  parameter int AF_MARGIN = 16
) (
  input logic          clk,
  input logic          rst,
  sample_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(DEPTH - AF_MARGIN);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] ram_cnt;
  logic [LW-1:0] level_q;
  logic [7:0]    head_q;
  logic          head_valid;
  logic          full_q;
  logic          af_q;
  logic          ovf_q;
  logic          unf_q;

  logic          wr_acc;
  logic          rd_acc;
  logic          load;
  logic          head_valid_nxt;
  logic [LW-1:0] ram_cnt_nxt;
  logic [LW-1:0] level_nxt;

  // Accept/refill decisions and next-state counts.
  always_comb begin
    wr_acc         = bus.wr_en & ~full_q;
    rd_acc         = bus.read & head_valid;
    // Head is refilled whenever it is empty or being popped and RAM has data;
    // this is what makes the second of two consecutive pops valid.
    load           = (ram_cnt != '0) & (~head_valid | rd_acc);
    head_valid_nxt = (head_valid & ~rd_acc) | load;
    ram_cnt_nxt    = ram_cnt + LW'(wr_acc) - LW'(load);
    level_nxt      = level_q + LW'(wr_acc) - LW'(rd_acc);
  end

  // RAM write port; contents are never reset, stale data is unreachable
  // because ram_cnt gates every read.
  always_ff @(posedge clk) begin
    if (rst && !bus.flush && wr_acc) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Pointers, head register, counts, registered status and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_cnt    <= '0;
      level_q    <= '0;
      head_q     <= 8'h00;
      head_valid <= 1'b0;
      full_q     <= 1'b0;
      af_q       <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_cnt    <= '0;
      level_q    <= '0;
      head_valid <= 1'b0;
      full_q     <= 1'b0;
      af_q       <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        head_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      ram_cnt    <= ram_cnt_nxt;
      level_q    <= level_nxt;
      head_valid <= head_valid_nxt;
      full_q     <= (level_nxt == FULL_LVL);
      af_q       <= (level_nxt >= AF_LVL);
      ovf_q      <= ovf_q | (bus.wr_en & full_q);
      unf_q      <= unf_q | (bus.read & ~head_valid);
    end
  end

  assign bus.sample      = head_q;
  assign bus.empty       = ~head_valid;
  assign bus.full        = full_q;
  assign bus.almost_full = af_q;
  assign bus.level       = level_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
endmodule

// File: tb/tb_sample_fifo.sv
// Bench for sample_fifo: two instances (DEPTH=32/AF_MARGIN=4 and DEPTH=8/
// AF_MARGIN=2) driven by identical stimulus, each compared against its own
// queue-level reference model.
module tb_sample_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, read, flush;
  logic [7:0] wr_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sample_fifo_if #(.DEPTH(32)) ifb ();
  sample_fifo_if #(.DEPTH(8))  ifs ();

  assign ifb.wr_en = wr_en;  assign ifb.wr_data = wr_data;
  assign ifb.read  = read;   assign ifb.flush   = flush;
  assign ifs.wr_en = wr_en;  assign ifs.wr_data = wr_data;
  assign ifs.read  = read;   assign ifs.flush   = flush;

  sample_fifo #(.DEPTH(32), .AF_MARGIN(4)) u_big   (.clk(clk), .rst(rst), .bus(ifb.slave));
  sample_fifo #(.DEPTH(8),  .AF_MARGIN(2)) u_small (.clk(clk), .rst(rst), .bus(ifs.slave));

  logic [7:0] o_sample [2];
  logic       o_empty [2], o_full [2], o_af [2], o_ovf [2], o_unf [2];
  int         o_level [2];

  assign o_sample[0] = ifb.sample;      assign o_sample[1] = ifs.sample;
  assign o_empty[0]  = ifb.empty;       assign o_empty[1]  = ifs.empty;
  assign o_full[0]   = ifb.full;        assign o_full[1]   = ifs.full;
  assign o_af[0]     = ifb.almost_full; assign o_af[1]     = ifs.almost_full;
  assign o_ovf[0]    = ifb.overflow;    assign o_ovf[1]    = ifs.overflow;
  assign o_unf[0]    = ifb.underflow;   assign o_unf[1]    = ifs.underflow;
  assign o_level[0]  = 32'(ifb.level);  assign o_level[1]  = 32'(ifs.level);

  // Reference model: an ordered list of stored bytes plus a "presented" flag.
  // A byte is presented after an edge iff some byte that was already stored
  // before that edge is still held afterwards.
  int         m_dep [2] = '{32, 8};
  int         m_mar [2] = '{4, 2};
  logic [7:0] m_buf [2][64];
  int         m_hd  [2];
  int         m_cnt [2];
  bit         m_vis [2], m_ovf [2], m_unf [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_hd[d] = 0; m_cnt[d] = 0; m_vis[d] = 0; m_ovf[d] = 0; m_unf[d] = 0;
    end
  endtask

  task automatic model_edge();
    bit is_full, ra, wa;
    int n_old;
    for (int d = 0; d < 2; d++) begin
      if (flush) begin
        m_cnt[d] = 0; m_vis[d] = 0; m_ovf[d] = 0; m_unf[d] = 0;
      end else begin
        is_full = (m_cnt[d] == m_dep[d]);
        ra      = read && m_vis[d];
        wa      = wr_en && !is_full;
        n_old   = m_cnt[d] - (ra ? 1 : 0);
        if (wr_en && is_full) m_ovf[d] = 1;
        if (read && !m_vis[d]) m_unf[d] = 1;
        if (ra) begin
          m_hd[d] = (m_hd[d] + 1) % 64;
          m_cnt[d]--;
        end
        if (wa) begin
          m_buf[d][(m_hd[d] + m_cnt[d]) % 64] = wr_data;
          m_cnt[d]++;
        end
        m_vis[d] = (n_old > 0);
      end
    end
  endtask

  task automatic step(input bit w, input logic [7:0] dat, input bit r, input bit f);
    wr_en = w; wr_data = dat; read = r; flush = f;
    @(posedge clk);
    model_edge();
    #1;
    wr_en = 0; read = 0; flush = 0;
  endtask

  task automatic test_reset();
    rst = 0; wr_en = 0; read = 0; flush = 0; wr_data = 8'h00;
    model_reset();
    #3;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_empty[d] !== 1'b1 || o_full[d] !== 1'b0 || o_af[d] !== 1'b0 ||
          o_ovf[d] !== 1'b0 || o_unf[d] !== 1'b0 || o_level[d] !== 0 || o_sample[d] !== 8'h00) begin
        errors++;
        $display("FAIL reset dut%0d: empty=%b full=%b af=%b ovf=%b unf=%b level=%0d sample=%h, required 1 0 0 0 0 0 00",
                 d, o_empty[d], o_full[d], o_af[d], o_ovf[d], o_unf[d], o_level[d], o_sample[d]);
      end
    end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_write_latency();
    step(1, 8'hA5, 0, 0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_empty[d] !== 1'b1 || o_level[d] !== 1) begin
        errors++;
        $display("FAIL wr_latency_k dut%0d: empty=%b level=%0d, required empty=1 level=1", d, o_empty[d], o_level[d]);
      end
    end
    step(0, 8'h00, 0, 0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_empty[d] !== 1'b0 || o_sample[d] !== 8'hA5 || o_level[d] !== 1) begin
        errors++;
        $display("FAIL wr_latency_k1 dut%0d: empty=%b sample=%h level=%0d, required 0 a5 1",
                 d, o_empty[d], o_sample[d], o_level[d]);
      end
    end
  endtask

  task automatic test_burst_pop();
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    step(0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_empty[d] !== !m_vis[d] || (m_vis[d] && o_sample[d] !== m_buf[d][m_hd[d]])) begin
          errors++;
          $display("FAIL burst_pop%0d dut%0d: empty=%b sample=%h, required empty=%b sample=%h",
                   i, d, o_empty[d], o_sample[d], !m_vis[d], m_buf[d][m_hd[d]]);
        end
      end
      checks++;
      if (o_sample[0] !== 8'(i)) begin
        errors++;
        $display("FAIL burst_order%0d: sample=%h, required %h", i, o_sample[0], 8'(i));
      end
      step(0, 8'h00, 1, 0);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_empty[d] !== 1'b1 || o_unf[d] !== m_unf[d] || o_ovf[d] !== m_ovf[d] || o_level[d] !== m_cnt[d]) begin
        errors++;
        $display("FAIL burst_end dut%0d: empty=%b unf=%b ovf=%b level=%0d, required 1 %b %b %0d",
                 d, o_empty[d], o_unf[d], o_ovf[d], o_level[d], m_unf[d], m_ovf[d], m_cnt[d]);
      end
    end
    checks++;
    if (o_unf[0] !== 1'b0) begin
      errors++;
      $display("FAIL burst_no_underflow: unf=%b, required 0", o_unf[0]);
    end
  endtask

  task automatic test_full();
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 9; i++) begin
      step(1, 8'(8'h40 + i), 0, 0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_full[d] !== (m_cnt[d] == m_dep[d]) || o_af[d] !== (m_cnt[d] >= m_dep[d] - m_mar[d]) ||
            o_level[d] !== m_cnt[d] || o_ovf[d] !== m_ovf[d]) begin
          errors++;
          $display("FAIL fill%0d dut%0d: full=%b af=%b level=%0d ovf=%b, required %b %b %0d %b",
                   i, d, o_full[d], o_af[d], o_level[d], o_ovf[d], m_cnt[d] == m_dep[d],
                   m_cnt[d] >= m_dep[d] - m_mar[d], m_cnt[d], m_ovf[d]);
        end
      end
    end
    checks++;
    if (o_full[1] !== 1'b1 || o_ovf[1] !== 1'b1 || o_level[1] !== 8 || o_af[1] !== 1'b1) begin
      errors++;
      $display("FAIL full_small: full=%b ovf=%b level=%0d af=%b, required 1 1 8 1",
               o_full[1], o_ovf[1], o_level[1], o_af[1]);
    end
    checks++;
    if (o_sample[1] !== 8'h40) begin
      errors++;
      $display("FAIL full_head: sample=%h, required 40", o_sample[1]);
    end
  endtask

  task automatic test_rw_last();
    step(0, 8'h00, 0, 1);
    step(1, 8'h11, 0, 0);
    step(0, 8'h00, 0, 0);
    step(1, 8'h3C, 1, 0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_empty[d] !== 1'b1 || o_level[d] !== 1) begin
        errors++;
        $display("FAIL rw_last_gap dut%0d: empty=%b level=%0d, required 1 1", d, o_empty[d], o_level[d]);
      end
    end
    step(0, 8'h00, 0, 0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_empty[d] !== 1'b0 || o_sample[d] !== 8'h3C || o_level[d] !== 1) begin
        errors++;
        $display("FAIL rw_last_data dut%0d: empty=%b sample=%h level=%0d, required 0 3c 1",
                 d, o_empty[d], o_sample[d], o_level[d]);
      end
    end
  endtask

  task automatic test_random();
    int wr_pct, rd_pct;
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, 8'($urandom), 0, 0);
      step(0, 8'h00, 1, 0);
    end
    for (int i = 0; i < 400; i++) begin
      wr_pct = ((i / 50) % 2 == 0) ? 75 : 30;
      rd_pct = 100 - wr_pct;
      step($urandom_range(99) < wr_pct, 8'($urandom), $urandom_range(99) < rd_pct, $urandom_range(199) == 0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_empty[d] !== !m_vis[d] || (m_vis[d] && o_sample[d] !== m_buf[d][m_hd[d]]) ||
            o_level[d] !== m_cnt[d] || o_full[d] !== (m_cnt[d] == m_dep[d]) ||
            o_af[d] !== (m_cnt[d] >= m_dep[d] - m_mar[d]) || o_ovf[d] !== m_ovf[d] ||
            o_unf[d] !== m_unf[d] || o_level[d] > m_dep[d]) begin
          errors++;
          $display("FAIL random%0d dut%0d: empty=%b sample=%h level=%0d full=%b af=%b ovf=%b unf=%b, required %b %h %0d %b %b %b %b",
                   i, d, o_empty[d], o_sample[d], o_level[d], o_full[d], o_af[d], o_ovf[d], o_unf[d],
                   !m_vis[d], m_buf[d][m_hd[d]], m_cnt[d], m_cnt[d] == m_dep[d],
                   m_cnt[d] >= m_dep[d] - m_mar[d], m_ovf[d], m_unf[d]);
        end
      end
    end
  endtask

  task automatic test_flush_reset();
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h80 + i), 0, 0);
    step(0, 8'h00, 0, 0);
    step(1, 8'h99, 1, 1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_empty[d] !== 1'b1 || o_level[d] !== 0 || o_full[d] !== 1'b0 || o_af[d] !== 1'b0 ||
          o_ovf[d] !== 1'b0 || o_unf[d] !== 1'b0) begin
        errors++;
        $display("FAIL flush dut%0d: empty=%b level=%0d full=%b af=%b ovf=%b unf=%b, required 1 0 0 0 0 0",
                 d, o_empty[d], o_level[d], o_full[d], o_af[d], o_ovf[d], o_unf[d]);
      end
    end
    step(1, 8'h5A, 0, 0);
    checks++;
    if (o_empty[0] !== 1'b1) begin
      errors++;
      $display("FAIL flush_wr_k: empty=%b, required 1", o_empty[0]);
    end
    step(0, 8'h00, 0, 0);
    checks++;
    if (o_empty[0] !== 1'b0 || o_sample[0] !== 8'h5A || o_level[0] !== 1) begin
      errors++;
      $display("FAIL flush_wr_k1: empty=%b sample=%h level=%0d, required 0 5a 1", o_empty[0], o_sample[0], o_level[0]);
    end
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 1, 0);
    step(0, 8'h00, 1, 0);
    wr_en = 1; wr_data = 8'h03;
    #2;
    rst = 0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_empty[d] !== 1'b1 || o_level[d] !== 0 || o_full[d] !== 1'b0 || o_af[d] !== 1'b0 ||
          o_ovf[d] !== 1'b0 || o_unf[d] !== 1'b0 || o_sample[d] !== 8'h00) begin
        errors++;
        $display("FAIL async_rst dut%0d: empty=%b level=%0d full=%b af=%b ovf=%b unf=%b sample=%h, required 1 0 0 0 0 0 00",
                 d, o_empty[d], o_level[d], o_full[d], o_af[d], o_ovf[d], o_unf[d], o_sample[d]);
      end
    end
    wr_en = 0;
    @(negedge clk);
    rst = 1;
    step(1, 8'hC7, 0, 0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_empty[d] !== 1'b1 || o_level[d] !== 1) begin
        errors++;
        $display("FAIL post_rst_k dut%0d: empty=%b level=%0d, required 1 1", d, o_empty[d], o_level[d]);
      end
    end
    step(0, 8'h00, 0, 0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_empty[d] !== 1'b0 || o_sample[d] !== 8'hC7) begin
        errors++;
        $display("FAIL post_rst_k1 dut%0d: empty=%b sample=%h, required 0 c7", d, o_empty[d], o_sample[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_burst_pop();
    test_full();
    test_rw_last();
    test_random();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
